// File: rtl/uart_tx_arbiter.sv
// Round-robin front end that shares one UART transmitter among 2**ID_W byte requesters,
// with multi-byte message locking and a watchdog that frees a stalled grant.
module uart_tx_arbiter #(
    parameter int ID_W        = 2,
    parameter int DATA_BITS   = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                           sys_clk,
    input  logic                           Async_rst,
    input  logic [2**ID_W-1:0]             req,
    input  logic [2**ID_W*DATA_BITS-1:0]   req_data,
    input  logic [2**ID_W-1:0]             req_last,
    output logic [2**ID_W-1:0]             req_ack,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_din,
    input  logic                           tx_done_tick,
    output logic                           busy,
    output logic [ID_W-1:0]                owner,
    output logic                           timeout_err
);

    localparam int N_REQ = 2**ID_W;
    localparam bit WD_EN = (TIMEOUT_CYC > 0);
    localparam logic [23:0] WD_LAST = WD_EN ? 24'(TIMEOUT_CYC - 1) : 24'd0;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

    state_t                 state;
    logic [ID_W-1:0]        ptr;
    logic                   last_q;
    logic [23:0]            wd_cnt;

    logic [DATA_BITS-1:0]   req_byte [N_REQ];
    logic [ID_W:0]          pick;
    logic [ID_W-1:0]        win;
    logic                   cap;
    logic                   done_ok;
    logic                   wd_fire;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_byte[g] = req_data[g*DATA_BITS +: DATA_BITS];
    end

    // First set request at or after the start index, wrapping; MSB flags a hit.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  start);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = start + k[ID_W-1:0];
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign pick = rr_pick(req, ptr);

    // While locked only the current owner may continue its message.
    always_comb begin
        win = owner;
        cap = 1'b0;
        case (state)
            IDLE: begin
                win = pick[ID_W-1:0];
                cap = pick[ID_W];
            end
            HOLD:    cap = req[owner];
            default: cap = 1'b0;
        endcase
    end

    // A done tick coinciding with our own start pulse belongs to an earlier frame.
    assign done_ok = (state == WAIT) && tx_done_tick && !tx_start;
    assign wd_fire = WD_EN && (wd_cnt == WD_LAST);
    assign busy    = (state != IDLE);

    always_ff @(posedge sys_clk or negedge Async_rst) begin
        if (!Async_rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            tx_din      <= '0;
            last_q      <= 1'b0;
            req_ack     <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            req_ack     <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (cap) begin
                        owner        <= win;
                        tx_din       <= req_byte[win];
                        last_q       <= req_last[win];
                        req_ack      <= N_REQ'(1) << win;
                        state        <= SEND;
                    end else if (state == HOLD) begin
                        if (wd_fire) begin
                            timeout_err <= 1'b1;
                            ptr         <= owner + 1'b1;
                            state       <= IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + 24'd1;
                        end
                    end
                end
                SEND: begin
                    tx_start <= 1'b1;
                    wd_cnt   <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (done_ok) begin
                        wd_cnt <= '0;
                        if (last_q) begin
                            ptr   <= owner + 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (wd_fire) begin
                        timeout_err <= 1'b1;
                        ptr         <= owner + 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences, and randomized
// message traffic checked against a message-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int TO = 50;

    logic        sys_clk = 1'b0;
    logic        Async_rst;
    logic [3:0]  req, req_last, req_ack;
    logic [31:0] req_data;
    logic        tx_start, tx_done_tick, busy, timeout_err;
    logic [7:0]  tx_din;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    bit uart_en, auto_req, lock_watch, ack2_early;
    int umin = 1, umax = 1, uart_cnt = 0, done_cnt = 0;

    logic [7:0] sent_q [$];
    logic [1:0] own_q  [$];
    logic [8:0] rq [4][$];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [1:0]  exp_owner;
        logic [7:0]  exp_byte;
    } vec_t;
    vec_t vecs [8];

    uart_tx_arbiter #(.ID_W(2), .DATA_BITS(8), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .Async_rst(Async_rst), .req(req), .req_data(req_data),
        .req_last(req_last), .req_ack(req_ack), .tx_start(tx_start), .tx_din(tx_din),
        .tx_done_tick(tx_done_tick), .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0) begin
                e = rq[i][0];
                req[i] = 1'b1;
                req_data[i*8 +: 8] = e[7:0];
                req_last[i] = e[8];
            end else begin
                req[i] = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i] = 1'b0;
            end
        end
    endtask

    // One clock of bench environment: UART responder, transmit log, requesters.
    task automatic step();
        @(posedge sys_clk);
        #1;
        cycle++;
        tx_done_tick = 1'b0;
        if (uart_en && uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                tx_done_tick = 1'b1;
                done_cnt++;
            end
        end
        if (tx_start) begin
            sent_q.push_back(tx_din);
            own_q.push_back(owner);
            uart_cnt = int'($urandom_range(umax, umin));
        end
        if (lock_watch && req_ack[2] && done_cnt < 3) ack2_early = 1'b1;
        if (auto_req) begin
            for (int i = 0; i < 4; i++)
                if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            drive();
        end
    endtask

    task automatic do_reset();
        Async_rst = 1'b0;
        auto_req = 1'b0; uart_en = 1'b0; lock_watch = 1'b0; ack2_early = 1'b0;
        req = '0; req_data = '0; req_last = '0; tx_done_tick = 1'b0;
        for (int i = 0; i < 4; i++) rq[i].delete();
        sent_q.delete(); own_q.delete();
        uart_cnt = 0; done_cnt = 0;
        step(); step();
        Async_rst = 1'b1;
        step();
    endtask

    task automatic wait_sent(input string name, input int n, input int budget);
        int c = 0;
        while (sent_q.size() < n && c < budget) begin step(); c++; end
        chk(name, sent_q.size(), n);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while (busy && c < budget) begin step(); c++; end
        chk(name, int'(busy), 0);
    endtask

    task automatic wait_timeout(input int budget);
        int c = 0;
        while (!timeout_err && c < budget) begin step(); c++; end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit reached at cycle %0d", cycle);
        $fatal(1, "bench time limit");
    end

    initial begin
        int c, c0;
        logic [7:0] exp_b [$];
        logic [1:0] exp_o [$];
        logic [8:0] mq [4][$];
        logic [8:0] e;

        // Reset state
        Async_rst = 1'b0;
        req = '0; req_data = '0; req_last = '0; tx_done_tick = 1'b0;
        step(); step();
        chk("rst_req_ack",     int'(req_ack), 0);
        chk("rst_tx_start",    int'(tx_start), 0);
        chk("rst_tx_din",      int'(tx_din), 0);
        chk("rst_busy",        int'(busy), 0);
        chk("rst_owner",       int'(owner), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);

        // Vector table: single-byte grants walking the round-robin pointer from 0
        vecs[0] = '{4'b0010, 32'h0000_A500, 2'd1, 8'hA5};
        vecs[1] = '{4'b0011, 32'h4433_2211, 2'd0, 8'h11};
        vecs[2] = '{4'b1001, 32'h4433_2211, 2'd3, 8'h44};
        vecs[3] = '{4'b1111, 32'h4433_2211, 2'd0, 8'h11};
        vecs[4] = '{4'b1100, 32'h4433_2211, 2'd2, 8'h33};
        vecs[5] = '{4'b0110, 32'h4433_2211, 2'd1, 8'h22};
        vecs[6] = '{4'b1000, 32'h4433_2211, 2'd3, 8'h44};
        vecs[7] = '{4'b0001, 32'h4433_2211, 2'd0, 8'h11};
        do_reset();
        uart_en = 1'b1; umin = 3; umax = 3;
        for (int v = 0; v < 8; v++) begin
            req = vecs[v].req; req_data = vecs[v].data; req_last = 4'hF;
            step();
            chk("vec_ack",       int'(req_ack), 1 << vecs[v].exp_owner);
            chk("vec_owner",     int'(owner), int'(vecs[v].exp_owner));
            chk("vec_busy_rise", int'(busy), 1);
            req = '0;
            step();
            chk("vec_tx_start",  int'(tx_start), 1);
            chk("vec_tx_din",    int'(tx_din), int'(vecs[v].exp_byte));
            chk("vec_ack_clear", int'(req_ack), 0);
            c = 0;
            while (!tx_done_tick && c < 100) begin step(); c++; end
            chk("vec_tick_seen", int'(tx_done_tick), 1);
            chk("vec_busy_hold", int'(busy), 1);
            step();
            chk("vec_busy_fall", int'(busy), 0);
            chk("vec_din_held",  int'(tx_din), int'(vecs[v].exp_byte));
        end

        // Fairness with slow transmitter; requester 0 keeps a second byte pending
        do_reset();
        uart_en = 1'b1; umin = 20; umax = 20; auto_req = 1'b1;
        rq[0].push_back({1'b1, 8'h10}); rq[0].push_back({1'b1, 8'h10});
        rq[1].push_back({1'b1, 8'h11});
        rq[2].push_back({1'b1, 8'h12});
        rq[3].push_back({1'b1, 8'h13});
        drive();
        wait_sent("fair_count", 5, 600);
        if (sent_q.size() >= 5) begin
            chk("fair_b0", int'(sent_q[0]), 'h10);
            chk("fair_b1", int'(sent_q[1]), 'h11);
            chk("fair_b2", int'(sent_q[2]), 'h12);
            chk("fair_b3", int'(sent_q[3]), 'h13);
            chk("fair_b4", int'(sent_q[4]), 'h10);
        end

        // Lock: requester 0 three-byte message while requester 2 waits
        do_reset();
        uart_en = 1'b1; umin = 2; umax = 4; auto_req = 1'b1; lock_watch = 1'b1;
        rq[0].push_back({1'b0, 8'h11}); rq[0].push_back({1'b0, 8'h22});
        rq[0].push_back({1'b1, 8'h33});
        rq[2].push_back({1'b1, 8'h44});
        drive();
        wait_sent("lock_count", 4, 400);
        if (sent_q.size() >= 4) begin
            chk("lock_b0", int'(sent_q[0]), 'h11);
            chk("lock_b1", int'(sent_q[1]), 'h22);
            chk("lock_b2", int'(sent_q[2]), 'h33);
            chk("lock_b3", int'(sent_q[3]), 'h44);
        end
        chk("lock_ack2_early", int'(ack2_early), 0);

        // Watchdog in WAIT: transmitter never answers, requester 3 waiting
        do_reset();
        auto_req = 1'b1;
        rq[0].push_back({1'b1, 8'h55});
        rq[3].push_back({1'b1, 8'h66});
        drive();
        wait_sent("wd_first_start", 1, 50);
        c0 = cycle;
        wait_timeout(200);
        chk("wd_wait_cycles", cycle - c0, TO);
        chk("wd_busy_low",    int'(busy), 0);
        step();
        chk("wd_pulse_width", int'(timeout_err), 0);
        chk("wd_next_ack",    int'(req_ack), 4'b1000);
        chk("wd_next_owner",  int'(owner), 3);
        wait_sent("wd_second_start", 2, 20);
        if (sent_q.size() >= 2) chk("wd_next_byte", int'(sent_q[1]), 'h66);

        // Watchdog in HOLD: owner drops req after a non-last byte
        do_reset();
        uart_en = 1'b1; umin = 2; umax = 2; auto_req = 1'b1;
        rq[1].push_back({1'b0, 8'h77});
        drive();
        c = 0;
        while (done_cnt < 1 && c < 100) begin step(); c++; end
        c0 = cycle;
        wait_timeout(300);
        chk("wd_hold_cycles",   cycle - c0, TO + 1);
        chk("wd_hold_busy_low", int'(busy), 0);

        // Stray done ticks in IDLE and in the start-pulse cycle
        do_reset();
        tx_done_tick = 1'b1;
        step();
        chk("stray_idle_busy",  int'(busy), 0);
        chk("stray_idle_start", int'(tx_start), 0);
        req = 4'b0100; req_data = 32'h003C_0000; req_last = 4'b0100;
        step();
        chk("stray_ack", int'(req_ack), 4'b0100);
        req = '0;
        step();
        chk("stray_start", int'(tx_start), 1);
        tx_done_tick = 1'b1;
        step();
        chk("stray_start_ignored", int'(busy), 1);
        step(); step();
        chk("stray_still_busy", int'(busy), 1);
        tx_done_tick = 1'b1;
        step();
        chk("stray_real_release", int'(busy), 0);

        // Asynchronous reset in the middle of WAIT
        do_reset();
        uart_en = 1'b1; umin = 2; umax = 2;
        req = 4'b0010; req_data = 32'h0000_2100; req_last = 4'b0010;
        step();
        req = '0;
        wait_idle("rst_pre_idle", 50);
        uart_en = 1'b0;
        req = 4'b0100; req_data = 32'h005A_0000; req_last = 4'b0100;
        step();
        req = '0;
        step(); step(); step();
        sent_q.delete();
        #3;
        Async_rst = 1'b0;
        #1;
        chk("mid_rst_busy",     int'(busy), 0);
        chk("mid_rst_owner",    int'(owner), 0);
        chk("mid_rst_tx_din",   int'(tx_din), 0);
        chk("mid_rst_tx_start", int'(tx_start), 0);
        chk("mid_rst_req_ack",  int'(req_ack), 0);
        chk("mid_rst_timeout",  int'(timeout_err), 0);
        step();
        Async_rst = 1'b1;
        step(); step(); step();
        chk("mid_rst_no_resume_busy", int'(busy), 0);
        chk("mid_rst_no_resume_tx",   sent_q.size(), 0);
        req = 4'b1010; req_data = 32'h4400_2200; req_last = 4'b1010;
        step();
        chk("mid_rst_ptr0_owner", int'(owner), 1);
        chk("mid_rst_ptr0_ack",   int'(req_ack), 4'b0010);
        req = 4'b1000;
        uart_en = 1'b1;
        step();
        wait_idle("mid_rst_first_done", 50);
        step();
        chk("mid_rst_owner3", int'(owner), 3);
        chk("mid_rst_ack3",   int'(req_ack), 4'b1000);
        req = '0;

        // Randomized message traffic against a message-level round-robin model
        for (int round = 0; round < 6; round++) begin
            int p, w, nm, len;
            bit fin;
            do_reset();
            for (int i = 0; i < 4; i++) begin
                nm = int'($urandom_range(3, 0));
                for (int m = 0; m < nm; m++) begin
                    len = int'($urandom_range(3, 1));
                    for (int b = 0; b < len; b++)
                        rq[i].push_back({(b == len - 1), 8'($urandom)});
                end
            end
            exp_b.delete(); exp_o.delete();
            for (int i = 0; i < 4; i++) mq[i] = rq[i];
            p = 0;
            fin = 1'b0;
            while (!fin) begin
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && mq[(p + k) % 4].size() > 0) w = (p + k) % 4;
                if (w < 0) begin
                    fin = 1'b1;
                end else begin
                    do begin
                        e = mq[w].pop_front();
                        exp_b.push_back(e[7:0]);
                        exp_o.push_back(2'(w));
                    end while (!e[8]);
                    p = (w + 1) % 4;
                end
            end
            uart_en = 1'b1; umin = 1; umax = 6; auto_req = 1'b1;
            drive();
            wait_sent("rand_count", exp_b.size(), 3000);
            for (int k = 0; k < exp_b.size() && k < sent_q.size(); k++) begin
                chk("rand_byte",  int'(sent_q[k]), int'(exp_b[k]));
                chk("rand_owner", int'(own_q[k]),  int'(exp_o[k]));
            end
            wait_idle("rand_final_idle", 100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART_TX serializer among N_REQ byte requesters. It grants the transmitter to one requester at a time and captures that requester's byte. It then issues the start pulse to UART_TX and waits for its done tick before serving the next byte. A grant stays locked for multi-byte messages until the byte flagged `last`, and a watchdog releases the lock if the transmitter or the owning requester stalls.

## Interface
- `ID_W`, 2: requester-index width; N_REQ = 2**ID_W requesters.
- `DATA_BITS`, 8: byte width; must match UART_TX.
- `TIMEOUT_CYC`, 200000: watchdog limit in sys_clk cycles, below 2**24; 0 disables the watchdog.

Ports:
- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `Async_rst`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  requester i has a byte pending.
- `req_data`  in  N_REQ*DATA_BITS  requester i's byte at [i*DATA_BITS +: DATA_BITS].
- `req_last`  in  N_REQ  requester i's byte is the last byte of its message.
- `req_ack`  out  N_REQ  one-cycle pulse; requester i's byte has been captured.
- `tx_start`  out  1  one-cycle start pulse to UART_TX.
- `tx_din`  out  DATA_BITS  byte to UART_TX; held stable from capture until the next capture.
- `tx_done_tick`  in  1  one-cycle pulse from UART_TX at the end of the stop bit.
- `busy`  out  1  high whenever state is not IDLE.
- `owner`  out  ID_W  index of the current or most recent grant.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States are IDLE, SEND, WAIT, and HOLD.
- IDLE, with any `req` bit set:
  - The winner is the first set `req` bit scanning ptr, ptr+1, … mod N_REQ.
  - Register `owner` <= winner, `tx_din` <= that requester's byte, last_q <= `req_last`[winner], `req_ack`[winner] <= 1.
  - Go to SEND.
- SEND: `tx_start` <= 1 and `req_ack` <= 0; go to WAIT; clear the watchdog counter.
- WAIT:
  - `tx_start` <= 0.
  - An accepted `tx_done_tick` goes to IDLE if last_q = 1, otherwise to HOLD. Both transitions clear the counter.
  - On the transition to IDLE, ptr <= owner+1 (mod N_REQ wrap).
- HOLD (locked):
  - Only `req`[owner] is examined; other requests wait.
  - When it is set, capture exactly as in IDLE, with the same winner (owner), and go to SEND.
- Watchdog:
  - The counter increments every cycle in WAIT and HOLD.
  - When it reaches TIMEOUT_CYC: pulse `timeout_err`, set ptr <= owner+1, go to IDLE.
  - No byte is re-sent after a timeout.
- `tx_done_tick` is accepted only in WAIT and only in cycles where `tx_start` is low. It is ignored in every other state or cycle.
- A `req` change made in the same cycle as `req_ack` has no effect on the captured byte.
- `req_data` and `req_last` matter only in the cycle in which they are sampled.

## Timing
- Reset (asynchronous, `Async_rst` = 0):
  - State is IDLE; ptr = 0.
  - `req_ack`, `tx_start`, `tx_din`, `busy`, `owner`, `timeout_err` are all 0.
  - Applies immediately, mid-frame included; no partial activity resumes after release.
- Let edge E be the edge at which `req` is sampled in IDLE or HOLD. Relative to E:
  - `req_ack` is high during cycle E+1.
  - `tx_start` is high during cycle E+2.
  - `tx_din` is valid from E+1 on.
- `busy` rises at E+1. It falls at the edge after the accepted `tx_done_tick` when last_q = 1, or after the watchdog fires.
- Minimum spacing between two captures is 3 cycles plus the UART frame time.
- Requesters present their next byte, or drop `req`, at or after the edge that ends their `req_ack` cycle.
- `timeout_err` occurs TIMEOUT_CYC cycles after entry to WAIT or HOLD.

## Test plan
- **Single byte:** `req`[1]=1, `req_data` byte 1 = 0xA5, `req_last`[1]=1.
  - `req_ack`=0010 at E+1; `tx_start` at E+2 with `tx_din`=0xA5; `owner`=1.
  - `busy` drops one cycle after `tx_done_tick`; the next scan starts at 2.
- **Fairness:** after reset, all four `req` set, each with last=1, bytes 0x10..0x13, bench returns done after 20 cycles.
  - Sent order is 0x10, 0x11, 0x12, 0x13.
  - Keeping `req`[0] high makes 0x10 the fifth byte.
- **Lock:** requester 0 sends 0x11, 0x22, 0x33 (last on 0x33) while `req`[2] is held high with 0x44.
  - Transmit order is 0x11, 0x22, 0x33, 0x44.
  - `req_ack`[2] never pulses before the done tick of 0x33.
- **Watchdog:** TIMEOUT_CYC=50, bench never returns `tx_done_tick`.
  - `timeout_err` pulses exactly 50 cycles after WAIT entry; `busy` returns to 0.
  - A pending `req`[3] is served next.
  - Also drop `req`[owner] in HOLD: same 50-cycle release.
- **Stray ticks:** `tx_done_tick` pulsed in IDLE, and in the `tx_start` cycle.
  - Both are ignored: no state change and no early release.
- **Reset mid-WAIT:** assert `Async_rst`=0 between clock edges.
  - All outputs go to 0 before the next edge; ptr=0.
  - After release, `req`=1000 is served with `owner`=3.
